addsub_result_stage: RTL
========================

// Module: addsub_result_stage
// PURPOSE
//  Registered output stage directly downstream of the 4-bit universal adder/subtractor.
//  Captures each Result/Cout with its mode and operand sign bits, derives flags
//  (borrow, signed overflow, zero) and buffers results in a 2-entry FIFO.
//  The FIFO decouples the combinational adder from a consumer that may stall (valid/ready).
// PARAMETERS
//  W   4  datapath width; must match the adder width
//  CW  8  width of the accepted-operation counter
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   adder output is a valid operation this cycle
//  in_ready     out  1   stage can accept (FIFO not full)
//  in_result    in   W   adder Result
//  in_cout      in   1   adder Cout
//  in_m         in   1   mode of this op: 0 = add, 1 = subtract
//  in_a_msb     in   1   A[W-1] of this op
//  in_b_msb     in   1   B[W-1] of this op (un-inverted B)
//  out_valid    out  1   head entry valid
//  out_ready    in   1   consumer takes head entry
//  out_result   out  W   head result
//  out_cout     out  1   head raw carry
//  out_borrow   out  1   head borrow = m & ~cout (0 for adds)
//  out_ovf      out  1   head two's-complement overflow
//  out_zero     out  1   head result == 0
//  op_count     out  CW  number of accepted ops, modulo 2^CW
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty; out_valid=0, in_ready=1; out_result, out_cout,
//    out_borrow, out_ovf, out_zero all 0; op_count=0. Buffered entries are discarded.
//  - Reset release: first acceptance on the first rising edge with rst_n=1 and in_valid=1.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - FSM on occupancy: EMPTY, ONE, TWO.
//      EMPTY: push -> ONE
//      ONE:   push & ~pop -> TWO; pop & ~push -> EMPTY; push & pop -> ONE
//      TWO:   pop -> ONE (push impossible: in_ready=0)
//  - in_ready = (state != TWO), registered-state only; no combinational path from out_ready.
//  - out_valid = (state != EMPTY), also registered-state only.
//  - Latency: op accepted at edge N is presented on out_* after edge N (visible in cycle N+1).
//  - Order strictly FIFO. Simultaneous push+pop in ONE: new entry becomes head next cycle.
//  - Flags are computed at capture and stored with the entry:
//      ovf add (m=0): (a_msb == b_msb) & (result[W-1] != a_msb)
//      ovf sub (m=1): (a_msb != b_msb) & (result[W-1] != a_msb)
//      zero: ~|result; borrow: m & ~cout.
//  - With FIFO empty, out_* data holds the last popped values (consumer must qualify with
//    out_valid). Only reset forces these outputs to 0.
//  - op_count increments by 1 on every push and wraps 2^CW-1 -> 0; pops do not affect it.
//  - in_valid while in_ready=0: no capture, no count; upstream must hold its operands.
// CONFIGURATION
//  Macro ADDSUB_STICKY_OVF_EN:
//   defined: adds ports sticky_ovf (out, 1) and clr_sticky (in, 1). sticky_ovf is set on any
//     push whose computed ovf=1 and cleared only by reset or clr_sticky=1. If clr_sticky=1
//     and an overflowing push occur in the same cycle, the set wins.
//   undefined: neither port exists; no sticky logic.
// TESTING (W=4)
//  1. Reset with in_valid=1 -> all outputs 0, in_ready=1, op_count=0; no capture during reset.
//  2. Add A=5,B=3 (res=8,cout=0), out_ready=1 -> next cycle out_valid=1, out_result=8,
//     out_ovf=1, out_borrow=0, out_zero=0.
//  3. Sub 3-5 (res=14,cout=0,m=1,a_msb=0,b_msb=0) -> out_result=14, out_borrow=1, out_ovf=0.
//     Sub 5-5 (res=0,cout=1) -> out_zero=1, out_borrow=0.
//  4. out_ready=0, push 3 ops -> in_ready=0 after 2nd push; 3rd is not captured,
//     op_count=2; release out_ready -> first two ops pop in order.
//  5. State ONE with push+pop in the same cycle -> stays ONE, head becomes the new op;
//     256 pushes -> op_count wraps to 0.
//  6. ADDSUB_STICKY_OVF_EN: overflowing add -> sticky_ovf=1 and stays 1 across
//     non-overflowing ops; clr_sticky=1 together with an overflowing push -> remains 1.
//     Assert rst_n=0 with 2 entries buffered -> FIFO empties immediately, sticky_ovf=0.

Source files
------------

// File: rtl/addsub_result_stage.sv
// rtl/addsub_result_stage.sv - flag-capturing 2-entry result FIFO behind the 4-bit adder/subtractor
// Optional sticky overflow flag: define ADDSUB_STICKY_OVF_EN.
module addsub_result_stage #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  in_result_i,
  input  logic          in_cout_i,
  input  logic          in_m_i,
  input  logic          in_a_msb_i,
  input  logic          in_b_msb_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  out_result_o,
  output logic          out_cout_o,
  output logic          out_borrow_o,
  output logic          out_ovf_o,
  output logic          out_zero_o,
`ifdef ADDSUB_STICKY_OVF_EN
  input  logic          clr_sticky_i,
  output logic          sticky_ovf_o,
`endif
  output logic [CW-1:0] op_count_o
);

  typedef struct packed {
    logic [W-1:0] result;
    logic         cout;
    logic         borrow;
    logic         ovf;
    logic         zero;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t        state_q, state_d;
  entry_t        head_q, head_d;
  entry_t        tail_q, tail_d;
  entry_t        new_entry;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic          sign_mismatch;

  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Overflow needs operand signs that match (add) or differ (sub), and a flipped result sign.
  assign sign_mismatch = (in_result_i[W-1] != in_a_msb_i);

  always_comb begin
    new_entry.result = in_result_i;
    new_entry.cout   = in_cout_i;
    new_entry.borrow = in_m_i & ~in_cout_i;
    new_entry.ovf    = in_m_i ? ((in_a_msb_i != in_b_msb_i) & sign_mismatch)
                              : ((in_a_msb_i == in_b_msb_i) & sign_mismatch);
    new_entry.zero   = ~|in_result_i;
  end

  // head_q drives out_* directly, so it keeps the last popped entry while empty.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = push ? count_q + {{(CW-1){1'b0}}, 1'b1} : count_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_result_o = head_q.result;
  assign out_cout_o   = head_q.cout;
  assign out_borrow_o = head_q.borrow;
  assign out_ovf_o    = head_q.ovf;
  assign out_zero_o   = head_q.zero;
  assign op_count_o   = count_q;

`ifdef ADDSUB_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // An overflowing push beats a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (push && new_entry.ovf) begin
      sticky_d = 1'b1;
    end else if (clr_sticky_i) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_ovf_o = sticky_q;
`endif

endmodule
